// File: rtl/out_fm_mem_access.sv
// out_fm_mem_access: memory-side engine for one output-feature-map tile.
// LOAD streams the tile from memory into the out_fm load FIFO. STORE drains
// the out_fm store FIFO through a 2-entry skid buffer into memory writes.
// Word order is channel-major, then row, then column.
module out_fm_mem_access #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int Tn      = 16,
  parameter int Tr      = 64,
  parameter int Tc      = 16,
  parameter int R       = 128,
  parameter int C       = 128,
  parameter int MAX_OUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] tile_base,
  input  logic          ld_start,
  output logic          ld_done,
  input  logic          st_start,
  output logic          st_done,
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_rd_addr,
  input  logic          mem_rd_ready,
  input  logic          mem_rd_data_valid,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_req,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic          mem_wr_ready,
  output logic          out_fm_ld_fifo_push,
  output logic [DW-1:0] out_fm_ld_fifo_data,
  input  logic          out_fm_ld_fifo_almost_full,
  output logic          out_fm_st_fifo_pop,
  input  logic [DW-1:0] out_fm_st_fifo_data,
  input  logic          out_fm_st_fifo_empty
);

  localparam int N     = Tn * Tr * Tc;
  localparam int CNT_W = $clog2(N + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int CW    = (Tc > 1) ? $clog2(Tc) : 1;
  localparam int RW    = (Tr > 1) ? $clog2(Tr) : 1;
  // Strides are taken modulo 2^AW so the address arithmetic wraps naturally.
  localparam logic [AW-1:0] ROW_STRIDE  = AW'(C);
  localparam logic [AW-1:0] CHAN_STRIDE = AW'(R * C);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STORE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t           state_r, state_nx_s;
  logic             ld_go_s, st_go_s;
  logic             rd_acc_s, rd_rsp_s, wr_req_s, wr_acc_s, pop_s, adv_s;
  logic             ld_done_nx_s, st_done_nx_s;
  logic             ld_done_r, st_done_r;
  logic [CNT_W-1:0] req_cnt_r, req_cnt_nx_s, fin_cnt_r, fin_cnt_nx_s;
  logic [OUT_W-1:0] out_r, out_nx_s;
  logic [CW-1:0]    c_r, c_nx_s;
  logic [RW-1:0]    r_r, r_nx_s;
  logic [AW-1:0]    row_r, row_nx_s, chan_r, chan_nx_s, gen_addr_nx_s, addr_r;
  logic             rd_req_r;
  logic             push_r;
  logic [DW-1:0]    push_data_r;
  logic [1:0]       occ_r;
  logic             pend_r;
  logic [DW-1:0]    buf0_r, buf1_r;

  assign ld_go_s  = (state_r == ST_IDLE) && ld_start;
  assign st_go_s  = (state_r == ST_IDLE) && st_start && !ld_start;
  assign rd_acc_s = rd_req_r && mem_rd_ready;
  assign rd_rsp_s = mem_rd_data_valid && (state_r == ST_LOAD);
  // The skid head is either a buffered word or the word arriving this cycle.
  assign wr_req_s = (occ_r != 2'd0) || pend_r;
  assign wr_acc_s = wr_req_s && mem_wr_ready;
  assign adv_s    = rd_acc_s || wr_acc_s;

  assign ld_done             = ld_done_r;
  assign st_done             = st_done_r;
  assign mem_rd_req          = rd_req_r;
  assign mem_rd_addr         = addr_r;
  assign mem_wr_req          = wr_req_s;
  assign mem_wr_addr         = addr_r;
  assign mem_wr_data         = (occ_r != 2'd0) ? buf0_r : (pend_r ? out_fm_st_fifo_data : {DW{1'b0}});
  assign out_fm_ld_fifo_push = push_r;
  assign out_fm_ld_fifo_data = push_data_r;
  assign out_fm_st_fifo_pop  = pop_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nx_s;
  end

  // Next-state logic: load wins a simultaneous start; done after N words.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld_go_s)      state_nx_s = ST_LOAD;
        else if (st_go_s) state_nx_s = ST_STORE;
        else              state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (push_r && (fin_cnt_r == CNT_W'(N - 1))) state_nx_s = ST_FINISH;
        else                                        state_nx_s = ST_LOAD;
      end
      ST_STORE: begin
        if (wr_acc_s && (fin_cnt_r == CNT_W'(N - 1))) state_nx_s = ST_FINISH;
        else                                          state_nx_s = ST_STORE;
      end
      ST_FINISH: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode: done pulses on the FINISH entry, store FIFO pop gating.
  always_comb begin
    ld_done_nx_s = (state_r == ST_LOAD)  && (state_nx_s == ST_FINISH);
    st_done_nx_s = (state_r == ST_STORE) && (state_nx_s == ST_FINISH);
    if (state_r == ST_STORE) begin
      pop_s = !out_fm_st_fifo_empty && (req_cnt_r < CNT_W'(N)) &&
              (({1'b0, occ_r} + {2'b00, pend_r}) < 3'd2);
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next values of the request, completion and outstanding counters.
  always_comb begin
    req_cnt_nx_s = req_cnt_r;
    fin_cnt_nx_s = fin_cnt_r;
    out_nx_s     = out_r;
    if (state_r == ST_IDLE) begin
      req_cnt_nx_s = '0;
      fin_cnt_nx_s = '0;
      out_nx_s     = '0;
    end else begin
      if (rd_acc_s || pop_s) req_cnt_nx_s = req_cnt_r + CNT_W'(1);
      else                   req_cnt_nx_s = req_cnt_r;
      if (push_r || wr_acc_s) fin_cnt_nx_s = fin_cnt_r + CNT_W'(1);
      else                    fin_cnt_nx_s = fin_cnt_r;
      case ({rd_acc_s, rd_rsp_s})
        2'b10:   out_nx_s = out_r + OUT_W'(1);
        2'b01:   out_nx_s = out_r - OUT_W'(1);
        default: out_nx_s = out_r;
      endcase
    end
  end

  // Address generator: c innermost, then r, then channel; reloaded on a start.
  always_comb begin
    c_nx_s    = c_r;
    r_nx_s    = r_r;
    row_nx_s  = row_r;
    chan_nx_s = chan_r;
    if (ld_go_s || st_go_s) begin
      c_nx_s    = '0;
      r_nx_s    = '0;
      row_nx_s  = tile_base;
      chan_nx_s = tile_base;
    end else if (adv_s) begin
      if (c_r == CW'(Tc - 1)) begin
        c_nx_s = '0;
        if (r_r == RW'(Tr - 1)) begin
          r_nx_s    = '0;
          chan_nx_s = chan_r + CHAN_STRIDE;
          row_nx_s  = chan_r + CHAN_STRIDE;
        end else begin
          r_nx_s   = r_r + RW'(1);
          row_nx_s = row_r + ROW_STRIDE;
        end
      end else begin
        c_nx_s = c_r + CW'(1);
      end
    end else begin
      c_nx_s = c_r;
    end
    gen_addr_nx_s = row_nx_s + AW'(c_nx_s);
  end

  // Generator state and the shared request address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_r    <= '0;
      r_r    <= '0;
      row_r  <= '0;
      chan_r <= '0;
      addr_r <= '0;
    end else begin
      c_r    <= c_nx_s;
      r_r    <= r_nx_s;
      row_r  <= row_nx_s;
      chan_r <= chan_nx_s;
      addr_r <= ((state_nx_s == ST_LOAD) || (state_nx_s == ST_STORE)) ? gen_addr_nx_s : '0;
    end
  end

  // Transfer counters and done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_cnt_r <= '0;
      fin_cnt_r <= '0;
      out_r     <= '0;
      ld_done_r <= 1'b0;
      st_done_r <= 1'b0;
    end else begin
      req_cnt_r <= req_cnt_nx_s;
      fin_cnt_r <= fin_cnt_nx_s;
      out_r     <= out_nx_s;
      ld_done_r <= ld_done_nx_s;
      st_done_r <= st_done_nx_s;
    end
  end

  // Read request: held until accepted, otherwise re-armed from next-cycle counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                rd_req_r <= 1'b0;
    else if (state_nx_s != ST_LOAD)          rd_req_r <= 1'b0;
    else if (rd_req_r && !mem_rd_ready)      rd_req_r <= 1'b1;
    else rd_req_r <= (req_cnt_nx_s < CNT_W'(N)) && (out_nx_s < OUT_W'(MAX_OUT)) &&
                     !out_fm_ld_fifo_almost_full;
  end

  // Read responses are registered and pushed to the load FIFO a cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_r      <= 1'b0;
      push_data_r <= '0;
    end else begin
      push_r      <= rd_rsp_s;
      push_data_r <= rd_rsp_s ? mem_rd_data : '0;
    end
  end

  // Store skid buffer: pending FIFO word lands in the head or the second slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r  <= 2'd0;
      pend_r <= 1'b0;
      buf0_r <= '0;
      buf1_r <= '0;
    end else if (state_r != ST_STORE) begin
      occ_r  <= 2'd0;
      pend_r <= 1'b0;
      buf0_r <= '0;
      buf1_r <= '0;
    end else begin
      pend_r <= pop_s;
      case (occ_r)
        2'd0: begin
          if (pend_r && !mem_wr_ready) begin
            buf0_r <= out_fm_st_fifo_data;
            occ_r  <= 2'd1;
          end else begin
            occ_r  <= 2'd0;
          end
        end
        2'd1: begin
          if (mem_wr_ready) begin
            if (pend_r) buf0_r <= out_fm_st_fifo_data;
            occ_r <= pend_r ? 2'd1 : 2'd0;
          end else if (pend_r) begin
            buf1_r <= out_fm_st_fifo_data;
            occ_r  <= 2'd2;
          end
        end
        2'd2: begin
          if (mem_wr_ready) begin
            buf0_r <= buf1_r;
            if (pend_r) buf1_r <= out_fm_st_fifo_data;
            occ_r <= pend_r ? 2'd2 : 2'd1;
          end
        end
        default: occ_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_out_fm_mem_access.sv
// Bench for out_fm_mem_access: reactive memory and FIFO models, reference
// addresses from the tile index arithmetic, randomized data/latency/ready.
module tb_out_fm_mem_access;
  localparam int AW = 12, DW = 32, TN = 2, TR = 2, TC = 2, RR = 4, CC = 4, MO = 2;
  localparam int NW = TN * TR * TC;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] tile_base;
  logic          ld_start, ld_done, st_start, st_done;
  logic          mem_rd_req, mem_rd_ready, mem_rd_data_valid;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
  logic          mem_wr_req, mem_wr_ready;
  logic          out_fm_ld_fifo_push, out_fm_ld_fifo_almost_full;
  logic [DW-1:0] out_fm_ld_fifo_data, out_fm_st_fifo_data;
  logic          out_fm_st_fifo_pop, out_fm_st_fifo_empty;

  out_fm_mem_access #(.AW(AW), .DW(DW), .Tn(TN), .Tr(TR), .Tc(TC), .R(RR), .C(CC), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .tile_base(tile_base),
    .ld_start(ld_start), .ld_done(ld_done), .st_start(st_start), .st_done(st_done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready),
    .out_fm_ld_fifo_push(out_fm_ld_fifo_push), .out_fm_ld_fifo_data(out_fm_ld_fifo_data),
    .out_fm_ld_fifo_almost_full(out_fm_ld_fifo_almost_full),
    .out_fm_st_fifo_pop(out_fm_st_fifo_pop), .out_fm_st_fifo_data(out_fm_st_fifo_data),
    .out_fm_st_fifo_empty(out_fm_st_fifo_empty)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int rd_lat, rd_rdy_mode, wr_rdy_mode, af_age;
  logic af_force, pulse_ld, pulse_st, rsp_now, pop_prev;
  logic [AW-1:0] base;
  logic [31:0] mem_seed, pop_word;
  int rsp_due[$];
  logic [31:0] rsp_dat[$];
  logic [31:0] stq[$];
  logic [31:0] exp_wr[NW];
  logic [AW-1:0] rd_log[$];
  int rd_acc_cnt, push_cnt, wr_acc_cnt, ld_done_cnt, st_done_cnt, outst, max_outst;
  int pop_cnt, wr_req_cycles, last_push_cyc, last_wr_cyc, first_pop_cyc, first_wr_cyc;
  logic prev_rd_pend, prev_wr_pend;
  logic [AW-1:0] prev_rd_addr, prev_wr_addr;
  logic [31:0] prev_wr_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference address of the k-th tile word, straight from the tile geometry.
  function automatic logic [AW-1:0] exp_addr(input int k);
    int n, r, c;
    n = k / (TR * TC);
    r = (k / TC) % TR;
    c = k % TC;
    return AW'(int'(base) + n * RR * CC + r * CC + c);
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return mem_seed ^ (32'(a) * 32'h0100_0193);
  endfunction

  task automatic clear_model();
    rsp_due.delete(); rsp_dat.delete(); rd_log.delete();
    rd_acc_cnt = 0; push_cnt = 0; wr_acc_cnt = 0; ld_done_cnt = 0; st_done_cnt = 0;
    outst = 0; max_outst = 0; pop_cnt = 0; wr_req_cycles = 0;
    last_push_cyc = -10; last_wr_cyc = -10; first_pop_cyc = -1; first_wr_cyc = -1;
    prev_rd_pend = 1'b0; prev_wr_pend = 1'b0; pop_prev = 1'b0; af_force = 1'b0; af_age = 0;
  endtask

  task automatic sample();
    if (prev_rd_pend) chk("rd_hold", 64'({mem_rd_req, mem_rd_addr}), 64'({1'b1, prev_rd_addr}));
    if (rsp_now) outst--;
    if (af_force) begin
      if (af_age > 0) chk("af_no_issue", 64'(mem_rd_req && mem_rd_ready), 64'd0);
      af_age++;
    end
    if (mem_rd_req && mem_rd_ready) begin
      chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr(rd_acc_cnt)));
      rd_log.push_back(mem_rd_addr);
      rsp_due.push_back(cyc + rd_lat);
      rsp_dat.push_back(mem_word(mem_rd_addr));
      rd_acc_cnt++;
      outst++;
      if (outst > max_outst) max_outst = outst;
      chk("rd_outstanding_le_max", 64'(outst <= MO), 64'd1);
    end
    prev_rd_pend = mem_rd_req && !mem_rd_ready;
    prev_rd_addr = mem_rd_addr;
    if (out_fm_ld_fifo_push) begin
      chk("push_data", 64'(out_fm_ld_fifo_data), 64'(mem_word(exp_addr(push_cnt))));
      push_cnt++;
      last_push_cyc = cyc;
    end
    if (ld_done) begin
      chk("ld_done_cycle", 64'(cyc), 64'(last_push_cyc + 1));
      ld_done_cnt++;
    end
    if (out_fm_st_fifo_pop) begin
      chk("pop_not_empty", 64'(stq.size() > 0), 64'd1);
      if (stq.size() > 0) pop_word = stq.pop_front();
      if (pop_cnt == 0) first_pop_cyc = cyc;
      pop_cnt++;
    end
    pop_prev = out_fm_st_fifo_pop;
    if (prev_wr_pend)
      chk("wr_hold", 64'({mem_wr_req, mem_wr_addr, mem_wr_data}), 64'({1'b1, prev_wr_addr, prev_wr_data}));
    if (mem_wr_req) wr_req_cycles++;
    if (mem_wr_req && mem_wr_ready) begin
      chk("wr_addr", 64'(mem_wr_addr), 64'(exp_addr(wr_acc_cnt)));
      chk("wr_data", 64'(mem_wr_data), 64'(exp_wr[wr_acc_cnt % NW]));
      if (wr_acc_cnt == 0) first_wr_cyc = cyc;
      wr_acc_cnt++;
      last_wr_cyc = cyc;
    end
    prev_wr_pend = mem_wr_req && !mem_wr_ready;
    prev_wr_addr = mem_wr_addr;
    prev_wr_data = mem_wr_data;
    if (st_done) begin
      chk("st_done_cycle", 64'(cyc), 64'(last_wr_cyc + 1));
      st_done_cnt++;
    end
  endtask

  // One clock: drive inputs just after the edge, check on the falling edge.
  task automatic cycle();
    @(posedge clk); #1;
    mem_rd_ready = (rd_rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (wr_rdy_mode)
      0:       mem_wr_ready = 1'b1;
      1:       mem_wr_ready = 1'($urandom_range(0, 1));
      default: mem_wr_ready = (cyc % 2 == 0);
    endcase
    rsp_now = 1'b0;
    mem_rd_data_valid = 1'b0;
    mem_rd_data = '0;
    if (rsp_due.size() > 0) begin
      if (rsp_due[0] <= cyc) begin
        rsp_now = 1'b1;
        mem_rd_data_valid = 1'b1;
        mem_rd_data = rsp_dat.pop_front();
        rsp_due.delete(0);
      end
    end
    out_fm_ld_fifo_almost_full = af_force;
    out_fm_st_fifo_empty = (stq.size() == 0);
    out_fm_st_fifo_data = pop_prev ? pop_word : 32'hDEAD_BEEF;
    ld_start = pulse_ld;
    st_start = pulse_st;
    pulse_ld = 1'b0;
    pulse_st = 1'b0;
    @(negedge clk);
    sample();
    cyc++;
  endtask

  task automatic wait_ld(input int budget);
    int n = 0;
    while (ld_done_cnt == 0 && n < budget) begin cycle(); n++; end
    chk("ld_done_seen", 64'(ld_done_cnt), 64'd1);
    repeat (3) cycle();
  endtask

  task automatic wait_st(input int budget);
    int n = 0;
    while (st_done_cnt == 0 && n < budget) begin cycle(); n++; end
    chk("st_done_seen", 64'(st_done_cnt), 64'd1);
    repeat (3) cycle();
  endtask

  task automatic preload_store(input logic [31:0] first, input logic rnd);
    for (int k = 0; k < NW; k++) begin
      exp_wr[k] = rnd ? $urandom : first + 32'(k);
      stq.push_back(exp_wr[k]);
    end
  endtask

  initial begin
    rst = 1'b0; tile_base = '0; ld_start = 1'b0; st_start = 1'b0;
    mem_rd_ready = 1'b0; mem_rd_data_valid = 1'b0; mem_rd_data = '0; mem_wr_ready = 1'b0;
    out_fm_ld_fifo_almost_full = 1'b0; out_fm_st_fifo_data = '0; out_fm_st_fifo_empty = 1'b1;
    mem_seed = $urandom; base = 12'h100; rd_lat = 1; rd_rdy_mode = 0; wr_rdy_mode = 0;
    pulse_ld = 1'b0; pulse_st = 1'b0; pop_word = '0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_rd", 64'({mem_rd_req, mem_rd_addr}), 64'd0);
    chk("rst_wr", 64'({mem_wr_req, mem_wr_addr, mem_wr_data}), 64'd0);
    chk("rst_misc", 64'({ld_done, st_done, out_fm_ld_fifo_push, out_fm_ld_fifo_data, out_fm_st_fifo_pop}), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Load address order, next-cycle memory response, always ready.
    tile_base = base; clear_model(); pulse_ld = 1'b1;
    wait_ld(100);
    chk("t1_pushes", 64'(push_cnt), 64'd8);
    chk("t1_reads", 64'(rd_acc_cnt), 64'd8);
    chk("t1_addr5", 64'(rd_log[5]), 64'h111);
    chk("t1_done_once", 64'(ld_done_cnt), 64'd1);

    // Load backpressure: latency 5, almost_full window mid-load.
    clear_model(); rd_lat = 5; pulse_ld = 1'b1;
    for (int n = 0; n < 100 && rd_acc_cnt < 3; n++) cycle();
    af_force = 1'b1; af_age = 0;
    repeat (10) cycle();
    af_force = 1'b0;
    wait_ld(300);
    chk("t2_pushes", 64'(push_cnt), 64'd8);
    chk("t2_max_outstanding", 64'(max_outst), 64'(MO));

    // Store with write ready toggling 1-0.
    clear_model(); wr_rdy_mode = 2; preload_store(32'hA0, 1'b0); pulse_st = 1'b1;
    wait_st(200);
    chk("t3_writes", 64'(wr_acc_cnt), 64'd8);
    chk("t3_fifo_drained", 64'(stq.size()), 64'd0);
    chk("t3_done_once", 64'(st_done_cnt), 64'd1);

    // Store throughput with ready held high.
    clear_model(); wr_rdy_mode = 0; preload_store(32'h0, 1'b1); pulse_st = 1'b1;
    wait_st(200);
    chk("t3b_pop_to_req", 64'(first_wr_cyc), 64'(first_pop_cyc + 1));
    chk("t3b_one_per_cycle", 64'(last_wr_cyc - first_wr_cyc), 64'd7);

    // Simultaneous starts, then a store start while busy.
    clear_model(); rd_lat = 1; preload_store(32'h0, 1'b1);
    pulse_ld = 1'b1; pulse_st = 1'b1;
    repeat (4) cycle();
    pulse_st = 1'b1;
    wait_ld(100);
    chk("t4_pushes", 64'(push_cnt), 64'd8);
    chk("t4_no_wr_req", 64'(wr_req_cycles), 64'd0);
    chk("t4_no_pop", 64'(pop_cnt), 64'd0);
    chk("t4_no_st_done", 64'(st_done_cnt), 64'd0);
    stq.delete();

    // Reset mid-load after three accepted reads.
    clear_model(); rd_lat = 2; pulse_ld = 1'b1;
    for (int n = 0; n < 100 && rd_acc_cnt < 3; n++) cycle();
    @(posedge clk); #1 rst = 1'b0; mem_rd_data_valid = 1'b0;
    #1;
    chk("t5_rst_rd", 64'({mem_rd_req, mem_rd_addr}), 64'd0);
    chk("t5_rst_wr", 64'({mem_wr_req, mem_wr_addr, mem_wr_data}), 64'd0);
    chk("t5_rst_misc", 64'({ld_done, st_done, out_fm_ld_fifo_push, out_fm_ld_fifo_data, out_fm_st_fifo_pop}), 64'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    pulse_ld = 1'b1;
    wait_ld(100);
    chk("t5_first_addr", 64'(rd_log[0]), 64'h100);
    chk("t5_pushes", 64'(push_cnt), 64'd8);

    // Address wrap at 2^AW, random latency and ready.
    base = 12'hFFE; tile_base = base; clear_model();
    rd_lat = $urandom_range(1, 4); rd_rdy_mode = 1; pulse_ld = 1'b1;
    wait_ld(400);
    chk("t6_addr0", 64'(rd_log[0]), 64'hFFE);
    chk("t6_addr1", 64'(rd_log[1]), 64'hFFF);
    chk("t6_addr2", 64'(rd_log[2]), 64'h002);
    chk("t6_pushes", 64'(push_cnt), 64'd8);

    // Randomized loads and stores at random tile bases.
    for (int it = 0; it < 3; it++) begin
      base = AW'($urandom); tile_base = base; clear_model();
      rd_lat = $urandom_range(1, 6); rd_rdy_mode = 1; pulse_ld = 1'b1;
      wait_ld(500);
      chk("rnd_ld_pushes", 64'(push_cnt), 64'd8);
      clear_model(); wr_rdy_mode = 1; preload_store(32'h0, 1'b1); pulse_st = 1'b1;
      wait_st(500);
      chk("rnd_st_writes", 64'(wr_acc_cnt), 64'd8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
